// File: rtl/wrr_arb_pkg.sv
// Shared types and default sizing for the weighted round-robin arbiter.
package wrr_arb_pkg;

  localparam int N_DEF  = 4;
  localparam int WW_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/wrr_arb_rr_pick.sv
// Combinational rotating-priority picker: first set req bit at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_id,
  output logic          any
);

  logic [IW:0]   sum_s;
  logic [IW-1:0] idx_s;
  logic          hit_s;

  // Walk N positions from ptr; the first requesting one wins and masks the rest.
  always_comb begin
    win    = '0;
    win_id = '0;
    any    = 1'b0;
    sum_s  = '0;
    idx_s  = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum_s      = {1'b0, ptr} + (IW+1)'(k);
      sum_s      = (sum_s >= (IW+1)'(N)) ? (sum_s - (IW+1)'(N)) : sum_s;
      idx_s      = sum_s[IW-1:0];
      hit_s      = req[idx_s] & ~any;
      win[idx_s] = win[idx_s] | hit_s;
      win_id     = hit_s ? idx_s : win_id;
      any        = any | req[idx_s];
    end
  end

endmodule

// File: rtl/wrr_arb.sv
// Weighted round-robin arbiter with registered one-hot grant.
// Define WRR_ARB_WEIGHT_EN for per-requester credits; otherwise plain round-robin, one beat per grant.
module wrr_arb
  import wrr_arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int WW = WW_DEF,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  input  logic [N*WW-1:0] weight,
  output logic [N-1:0]  gnt,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_id
);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          vld_q, vld_d;
  logic [IW-1:0] id_q, id_d;

  logic          own_req_s;
  logic          exhausted_s;
  logic          release_s;
  logic [IW-1:0] nxt_ptr_s;
  logic [IW-1:0] pick_ptr_s;
  logic [N-1:0]  win_s;
  logic [IW-1:0] win_id_s;
  logic          any_s;

`ifdef WRR_ARB_WEIGHT_EN
  logic [WW-1:0] credit_q, credit_d;
  logic [WW-1:0] wt_arr_s [N];
  logic [WW-1:0] wt_sel_s;
  logic [WW-1:0] load_s;

  for (genvar g = 0; g < N; g++) begin : g_wt
    assign wt_arr_s[g] = weight[g*WW +: WW];
  end

  // Credit for a new winner; a zero weight still buys one beat.
  always_comb begin
    wt_sel_s = wt_arr_s[win_id_s];
    load_s   = (wt_sel_s == '0) ? '0 : (wt_sel_s - WW'(1));
  end

  assign exhausted_s = (credit_q == '0);
`else
  logic unused_weight_s;
  assign unused_weight_s = ^weight;
  assign exhausted_s     = 1'b1;
`endif

  assign own_req_s  = req[id_q];
  assign nxt_ptr_s  = (id_q == IW'(N-1)) ? '0 : (id_q + IW'(1));
  assign release_s  = (state_q == GRANT) & (~own_req_s | exhausted_s);
  // On release the scan restarts just past the old owner, making it lowest priority.
  assign pick_ptr_s = release_s ? nxt_ptr_s : ptr_q;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (pick_ptr_s),
    .win    (win_s),
    .win_id (win_id_s),
    .any    (any_s)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    id_d    = id_q;
`ifdef WRR_ARB_WEIGHT_EN
    credit_d = credit_q;
`endif
    case (state_q)
      IDLE, GRANT: begin
        if ((state_q == IDLE) || release_s) begin
          ptr_d = release_s ? nxt_ptr_s : ptr_q;
          if (any_s) begin
            state_d = GRANT;
            gnt_d   = win_s;
            vld_d   = 1'b1;
            id_d    = win_id_s;
`ifdef WRR_ARB_WEIGHT_EN
            credit_d = load_s;
`endif
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            vld_d   = 1'b0;
            id_d    = '0;
`ifdef WRR_ARB_WEIGHT_EN
            credit_d = '0;
`endif
          end
        end else begin
`ifdef WRR_ARB_WEIGHT_EN
          credit_d = credit_q - WW'(1);
`endif
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
        gnt_d   = '0;
        vld_d   = 1'b0;
        id_d    = '0;
`ifdef WRR_ARB_WEIGHT_EN
        credit_d = '0;
`endif
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
`ifdef WRR_ARB_WEIGHT_EN
      credit_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
`ifdef WRR_ARB_WEIGHT_EN
      credit_q <= credit_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = vld_q;
  assign gnt_id  = id_q;

endmodule

// File: tb/tb_wrr_arb.sv
// Table-driven bench for wrr_arb (N=4, WW=4); expectations follow whichever build WRR_ARB_WEIGHT_EN selects.
module tb_wrr_arb;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [15:0] weight = 16'h0000;
  logic [3:0]  gnt;
  logic        gnt_vld;
  logic [1:0]  gnt_id;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        rstn;
    logic [3:0]  req;
    logic [15:0] wt;
    logic [3:0]  gnt;
    logic [1:0]  id;
  } vec_t;

  vec_t vq[$];

  wrr_arb #(.N(4), .WW(4)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req),
    .weight  (weight),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic [3:0] q, input logic [15:0] w,
                              input logic [3:0] g, input logic [1:0] i);
    vec_t v;
    v.rstn = r; v.req = q; v.wt = w; v.gnt = g; v.id = i;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic [15:0] w);
    @(negedge clk);
    rstn = r; req = q; weight = w;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input int idx, input logic [3:0] g, input logic [1:0] i);
    chk({name, ".gnt"}, idx, 32'(gnt), 32'(g));
    chk({name, ".vld"}, idx, 32'(gnt_vld), 32'(g != 4'b0000));
    chk({name, ".id"}, idx, 32'(gnt_id), 32'(i));
  endtask

  initial begin
    // Plain rotation, all weights 1.
    add(1'b0, 4'b0000, 16'h1111, 4'b0000, 2'd0);
    add(1'b1, 4'b1111, 16'h1111, 4'b0001, 2'd0);
    add(1'b1, 4'b1111, 16'h1111, 4'b0010, 2'd1);
    add(1'b1, 4'b1111, 16'h1111, 4'b0100, 2'd2);
    add(1'b1, 4'b1111, 16'h1111, 4'b1000, 2'd3);
    add(1'b1, 4'b1111, 16'h1111, 4'b0001, 2'd0);
    add(1'b0, 4'b1111, 16'h1111, 4'b0000, 2'd0);
`ifdef WRR_ARB_WEIGHT_EN
    // Weights {4,1,2,3}: 0,0,0,1,1,2,3,3,3,3, then repeat.
    add(1'b1, 4'b1111, 16'h4123, 4'b0001, 2'd0);
    add(1'b1, 4'b1111, 16'h4123, 4'b0001, 2'd0);
    add(1'b1, 4'b1111, 16'h4123, 4'b0001, 2'd0);
    add(1'b1, 4'b1111, 16'h4123, 4'b0010, 2'd1);
    add(1'b1, 4'b1111, 16'h4123, 4'b0010, 2'd1);
    add(1'b1, 4'b1111, 16'h4123, 4'b0100, 2'd2);
    add(1'b1, 4'b1111, 16'h4123, 4'b1000, 2'd3);
    add(1'b1, 4'b1111, 16'h4123, 4'b1000, 2'd3);
    add(1'b1, 4'b1111, 16'h4123, 4'b1000, 2'd3);
    add(1'b1, 4'b1111, 16'h4123, 4'b1000, 2'd3);
    add(1'b1, 4'b1111, 16'h4123, 4'b0001, 2'd0);
    add(1'b1, 4'b1111, 16'h4123, 4'b0001, 2'd0);
    add(1'b0, 4'b1111, 16'h4123, 4'b0000, 2'd0);
    // Zero weights behave as one beat each.
    add(1'b1, 4'b1010, 16'h0000, 4'b0010, 2'd1);
    add(1'b1, 4'b1010, 16'h0000, 4'b1000, 2'd3);
    add(1'b1, 4'b1010, 16'h0000, 4'b0010, 2'd1);
    add(1'b1, 4'b1010, 16'h0000, 4'b1000, 2'd3);
`else
    // Weights ignored: strict one-beat rotation.
    add(1'b1, 4'b1111, 16'h4123, 4'b0001, 2'd0);
    add(1'b1, 4'b1111, 16'h4123, 4'b0010, 2'd1);
    add(1'b1, 4'b1111, 16'h4123, 4'b0100, 2'd2);
    add(1'b1, 4'b1111, 16'h4123, 4'b1000, 2'd3);
    add(1'b1, 4'b1111, 16'h4123, 4'b0001, 2'd0);
    add(1'b0, 4'b1111, 16'h4123, 4'b0000, 2'd0);
    add(1'b1, 4'b1010, 16'h7777, 4'b0010, 2'd1);
    add(1'b1, 4'b1010, 16'h7777, 4'b1000, 2'd3);
    add(1'b1, 4'b1010, 16'h7777, 4'b0010, 2'd1);
    add(1'b1, 4'b1010, 16'h7777, 4'b1000, 2'd3);
`endif
    // Owner 3 drops with nothing else pending: back to idle, ptr wraps to 0.
    add(1'b1, 4'b0000, 16'h0000, 4'b0000, 2'd0);
    add(1'b1, 4'b0000, 16'h0000, 4'b0000, 2'd0);
    add(1'b1, 4'b1001, 16'h0000, 4'b0001, 2'd0);
    add(1'b1, 4'b1001, 16'h0000, 4'b1000, 2'd3);
    add(1'b1, 4'b1001, 16'h0000, 4'b0001, 2'd0);
    add(1'b0, 4'b0000, 16'h0000, 4'b0000, 2'd0);
`ifdef WRR_ARB_WEIGHT_EN
    // Requester 1 drops mid-credit while 3 waits.
    add(1'b1, 4'b0010, 16'h0030, 4'b0010, 2'd1);
    add(1'b1, 4'b1010, 16'h0030, 4'b0010, 2'd1);
    add(1'b1, 4'b1000, 16'h0030, 4'b1000, 2'd3);
    add(1'b1, 4'b0000, 16'h0030, 4'b0000, 2'd0);
    add(1'b1, 4'b0010, 16'h0030, 4'b0010, 2'd1);
    add(1'b1, 4'b0010, 16'h0030, 4'b0010, 2'd1);
    add(1'b1, 4'b0000, 16'h0030, 4'b0000, 2'd0);
    add(1'b1, 4'b1011, 16'h0030, 4'b1000, 2'd3);
`else
    add(1'b1, 4'b0010, 16'h0030, 4'b0010, 2'd1);
    add(1'b1, 4'b1010, 16'h0030, 4'b1000, 2'd3);
    add(1'b1, 4'b1010, 16'h0030, 4'b0010, 2'd1);
    add(1'b1, 4'b0000, 16'h0030, 4'b0000, 2'd0);
    add(1'b1, 4'b1011, 16'h0030, 4'b1000, 2'd3);
`endif

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rstn, vq[i].req, vq[i].wt);
      chk_out("vec", i, vq[i].gnt, vq[i].id);
    end

    // Reset in the middle of a grant to requester 2, then restart from ptr 0.
    step(1'b0, 4'b0000, 16'h0300);
    step(1'b1, 4'b0100, 16'h0300);
    chk_out("rst_mid.grant", 0, 4'b0100, 2'd2);
    step(1'b0, 4'b0110, 16'h0300);
    chk_out("rst_mid.drop", 1, 4'b0000, 2'd0);
    step(1'b1, 4'b0110, 16'h0300);
    chk_out("rst_mid.first", 2, 4'b0010, 2'd1);

    // Lone requester 2 keeps the grant without a bubble across credit reloads.
    step(1'b0, 4'b0000, 16'h0200);
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 4'b0100, 16'h0200);
      chk_out("lone", c, 4'b0100, 2'd2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
